// File: rtl/alu_pipeline_fwd.sv
// Three-stage (IR / EX / WB) ALU pipeline with an internal 32-entry register file and
// an optional EX/WB-to-decode forwarding path.
module alu_pipeline_fwd #(
  parameter int unsigned DATA_W       = 32,
  parameter bit          SIGN_EXT_IMM = 1'b0,
  parameter bit          FORWARD_EN   = 1'b1
) (
  input  logic              i_clk,
  input  logic              i_rst_n,
  input  logic [31:0]       i_instr,
  input  logic              i_instr_valid,
  input  logic              i_write_enable,
  output logic [DATA_W-1:0] o_alu_out,
  output logic              o_out_valid,
  output logic              o_ovf,
  output logic              o_illegal_op
);

  localparam int unsigned MSB = DATA_W - 1;

  localparam logic [2:0] FN_NOT = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_AND = 3'b101;
  localparam logic [2:0] FN_SLT = 3'b110;
  localparam logic [2:0] FN_XOR = 3'b111;

  // Stage 1: instruction register
  logic [31:0] r_ir;
  logic        r_ir_valid;
  logic        r_ir_we;

  // Stage 2 outputs (EX/WB slot)
  logic [DATA_W-1:0] r_alu_out;
  logic              r_out_valid;
  logic              r_ovf;
  logic              r_illegal;
  logic [4:0]        r_dest;
  logic              r_wr;

  logic [DATA_W-1:0] r_regs [32];

  // Decode
  logic [5:0]        w_opcode;
  logic [2:0]        w_fn;
  logic [4:0]        w_rd;
  logic [4:0]        w_rs;
  logic [4:0]        w_rt;
  logic [15:0]       w_imm;
  logic              w_is_itype;
  logic              w_legal;
  logic [DATA_W-1:0] w_imm_ext;

  assign w_opcode   = r_ir[31:26];
  assign w_fn       = w_opcode[2:0];
  assign w_is_itype = w_opcode[3];
  assign w_rd       = r_ir[25:21];
  assign w_rs       = r_ir[20:16];
  assign w_rt       = r_ir[15:11];
  assign w_imm      = r_ir[15:0];
  assign w_legal    = (w_opcode[5:4] == 2'b01) && (w_fn != 3'b000);

  always_comb begin
    w_imm_ext        = '0;
    w_imm_ext[15:0]  = w_imm;
    for (int i = 16; i < DATA_W; i++) begin
      w_imm_ext[i] = SIGN_EXT_IMM && w_imm[15];
    end
  end

  // Register read with forwarding from the EX/WB slot
  logic              w_slot_writes;
  logic              w_fwd_a;
  logic              w_fwd_b;
  logic [DATA_W-1:0] w_rs_val;
  logic [DATA_W-1:0] w_rt_val;
  logic [DATA_W-1:0] w_op_a;
  logic [DATA_W-1:0] w_op_b;

  assign w_slot_writes = FORWARD_EN && r_out_valid && r_wr;
  assign w_fwd_a       = w_slot_writes && (r_dest == w_rs);
  assign w_fwd_b       = w_slot_writes && (r_dest == w_rt);
  assign w_rs_val      = w_fwd_a ? r_alu_out : r_regs[w_rs];
  assign w_rt_val      = w_fwd_b ? r_alu_out : r_regs[w_rt];
  assign w_op_a        = w_rs_val;
  assign w_op_b        = w_is_itype ? w_imm_ext : w_rt_val;

  // Execute
  logic [DATA_W-1:0] w_sum;
  logic [DATA_W-1:0] w_diff;
  logic              w_slt;
  logic [DATA_W-1:0] w_result;
  logic              w_ovf;

  assign w_sum  = w_op_a + w_op_b;
  assign w_diff = w_op_a - w_op_b;
  assign w_slt  = $signed(w_op_a) < $signed(w_op_b);

  always_comb begin
    w_result = '0;
    w_ovf    = 1'b0;
    case (w_fn)
      FN_NOT: w_result = ~w_op_a;
      FN_ADD: begin
        w_result = w_sum;
        w_ovf    = (w_op_a[MSB] == w_op_b[MSB]) && (w_sum[MSB] != w_op_a[MSB]);
      end
      FN_SUB: begin
        w_result = w_diff;
        w_ovf    = (w_op_a[MSB] != w_op_b[MSB]) && (w_diff[MSB] != w_op_a[MSB]);
      end
      FN_OR:   w_result = w_op_a | w_op_b;
      FN_AND:  w_result = w_op_a & w_op_b;
      FN_SLT:  w_result[0] = w_slt;
      FN_XOR:  w_result = w_op_a ^ w_op_b;
      default: ;
    endcase
    if (!w_legal) begin
      w_result = '0;
      w_ovf    = 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_ir       <= '0;
      r_ir_valid <= 1'b0;
      r_ir_we    <= 1'b0;
    end else begin
      r_ir       <= i_instr;
      r_ir_valid <= i_instr_valid;
      r_ir_we    <= i_write_enable;
    end
  end

  // A bubble keeps the last result on ALUOut but clears every qualifier
  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      r_alu_out   <= '0;
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_dest      <= '0;
      r_wr        <= 1'b0;
    end else if (r_ir_valid) begin
      r_alu_out   <= w_result;
      r_out_valid <= w_legal;
      r_ovf       <= w_ovf;
      r_illegal   <= !w_legal;
      r_dest      <= w_rd;
      r_wr        <= r_ir_we;
    end else begin
      r_out_valid <= 1'b0;
      r_ovf       <= 1'b0;
      r_illegal   <= 1'b0;
      r_wr        <= 1'b0;
    end
  end

  always_ff @(posedge i_clk or negedge i_rst_n) begin
    if (!i_rst_n) begin
      for (int i = 0; i < 32; i++) begin
        r_regs[i] <= '0;
      end
    end else if (r_out_valid && r_wr) begin
      r_regs[r_dest] <= r_alu_out;
    end
  end

  assign o_alu_out    = r_alu_out;
  assign o_out_valid  = r_out_valid;
  assign o_ovf        = r_ovf;
  assign o_illegal_op = r_illegal;

endmodule

// File: tb/tb_alu_pipeline_fwd.sv
// Scoreboard bench for alu_pipeline_fwd: four parameterisations share one stimulus stream,
// expected results are queued at issue time and compared when they leave EX/WB.
module tb_alu_pipeline_fwd;

  localparam logic [2:0] FN_NOT = 3'b001;
  localparam logic [2:0] FN_ADD = 3'b010;
  localparam logic [2:0] FN_SUB = 3'b011;
  localparam logic [2:0] FN_OR  = 3'b100;
  localparam logic [2:0] FN_AND = 3'b101;
  localparam logic [2:0] FN_SLT = 3'b110;
  localparam logic [2:0] FN_XOR = 3'b111;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [31:0] instr;
  logic        ivalid;
  logic        iwe;

  logic [31:0] out_w [4];
  logic [15:0] out16;
  logic        val_w [4];
  logic        ovf_w [4];
  logic        ill_w [4];

  int checks = 0;
  int errors = 0;
  int cyc    = 0;

  typedef struct {
    string       tag;
    int          dut;
    int          due;
    logic [31:0] out;
    bit          chk_out;
    logic        valid;
    logic        ovf;
    logic        ill;
  } exp_t;

  exp_t sb[$];

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // 0: 32b zero-ext fwd, 1: 32b no fwd, 2: 32b sign-ext fwd, 3: 16b zero-ext fwd
  alu_pipeline_fwd #(.DATA_W(32), .SIGN_EXT_IMM(1'b0), .FORWARD_EN(1'b1)) u_dut0 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(ivalid),
    .i_write_enable(iwe), .o_alu_out(out_w[0]), .o_out_valid(val_w[0]),
    .o_ovf(ovf_w[0]), .o_illegal_op(ill_w[0])
  );
  alu_pipeline_fwd #(.DATA_W(32), .SIGN_EXT_IMM(1'b0), .FORWARD_EN(1'b0)) u_dut1 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(ivalid),
    .i_write_enable(iwe), .o_alu_out(out_w[1]), .o_out_valid(val_w[1]),
    .o_ovf(ovf_w[1]), .o_illegal_op(ill_w[1])
  );
  alu_pipeline_fwd #(.DATA_W(32), .SIGN_EXT_IMM(1'b1), .FORWARD_EN(1'b1)) u_dut2 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(ivalid),
    .i_write_enable(iwe), .o_alu_out(out_w[2]), .o_out_valid(val_w[2]),
    .o_ovf(ovf_w[2]), .o_illegal_op(ill_w[2])
  );
  alu_pipeline_fwd #(.DATA_W(16), .SIGN_EXT_IMM(1'b0), .FORWARD_EN(1'b1)) u_dut3 (
    .i_clk(clk), .i_rst_n(rst_n), .i_instr(instr), .i_instr_valid(ivalid),
    .i_write_enable(iwe), .o_alu_out(out16), .o_out_valid(val_w[3]),
    .o_ovf(ovf_w[3]), .o_illegal_op(ill_w[3])
  );
  assign out_w[3] = {16'h0000, out16};

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %h expected %h", tag, got, exp);
    end
  endtask

  task automatic chk_bit(input string tag, input logic got, input logic exp);
    checks++;
    assert (got === exp) else begin
      errors++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  always @(negedge clk) begin
    exp_t e;
    while (sb.size() > 0 && sb[0].due <= cyc) begin
      e = sb.pop_front();
      if (e.chk_out) chk({e.tag, ".out"}, out_w[e.dut], e.out);
      chk_bit({e.tag, ".valid"}, val_w[e.dut], e.valid);
      chk_bit({e.tag, ".ovf"}, ovf_w[e.dut], e.ovf);
      chk_bit({e.tag, ".illegal"}, ill_w[e.dut], e.ill);
    end
  end

  function automatic logic [31:0] rtype(input logic [2:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [4:0] rt);
    return {3'b010, fn, rd, rs, rt, 11'h000};
  endfunction

  function automatic logic [31:0] itype(input logic [2:0] fn, input logic [4:0] rd,
                                        input logic [4:0] rs, input logic [15:0] imm);
    return {3'b011, fn, rd, rs, imm};
  endfunction

  // Extra expectation for the instruction issued in this same time step
  task automatic also(input int dut, input string tag, input logic [31:0] eout, input bit chk_out,
                      input logic evalid, input logic eovf, input logic eill);
    exp_t e;
    e = '{tag, dut, cyc + 2, eout, chk_out, evalid, eovf, eill};
    sb.push_back(e);
  endtask

  task automatic issue(input logic [31:0] ins, input logic v, input logic we, input int dut,
                       input string tag, input logic [31:0] eout, input bit chk_out,
                       input logic evalid, input logic eovf, input logic eill);
    @(negedge clk);
    instr  = ins;
    ivalid = v;
    iwe    = we;
    also(dut, tag, eout, chk_out, evalid, eovf, eill);
  endtask

  task automatic op(input logic [31:0] ins, input int dut, input string tag,
                    input logic [31:0] eout, input logic eovf);
    issue(ins, 1'b1, 1'b1, dut, tag, eout, 1'b1, 1'b1, eovf, 1'b0);
  endtask

  // Bubble carries a garbage word with write enable high; it must be ignored
  task automatic bub(input int dut, input string tag, input logic [31:0] hold, input bit chk_out);
    issue($urandom(), 1'b0, 1'b1, dut, tag, hold, chk_out, 1'b0, 1'b0, 1'b0);
  endtask

  task automatic all_zero(input string tag);
    for (int d = 0; d < 4; d++) begin
      chk($sformatf("%s.d%0d.out", tag, d), out_w[d], 32'h0);
      chk_bit($sformatf("%s.d%0d.valid", tag, d), val_w[d], 1'b0);
      chk_bit($sformatf("%s.d%0d.ovf", tag, d), ovf_w[d], 1'b0);
      chk_bit($sformatf("%s.d%0d.illegal", tag, d), ill_w[d], 1'b0);
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: observed no finish, expected finish before 200000");
    $fatal(1, "watchdog expired");
  end

  initial begin
    logic [31:0] dbl;
    rst_n  = 1'b0;
    instr  = 32'h0;
    ivalid = 1'b0;
    iwe    = 1'b0;
    repeat (10) @(posedge clk);
    #1 all_zero("reset");
    @(negedge clk);
    rst_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      bub(0, "idle0", 32'h0, 1'b1);
      for (int d = 1; d < 4; d++) also(d, "idle", 32'h0, 1'b1, 1'b0, 1'b0, 1'b0);
    end
    op(rtype(FN_OR, 5'd3, 5'd3, 5'd3), 0, "rd_r3", 32'h0, 1'b0);
    op(rtype(FN_OR, 5'd4, 5'd31, 5'd17), 0, "rd_r31_r17", 32'h0, 1'b0);

    // Back-to-back dependent chain
    op(itype(FN_ADD, 5'd1, 5'd1, 16'h000A), 0, "iadd_r1", 32'h0000000A, 1'b0);
    also(1, "iadd_r1.nf", 32'h0000000A, 1'b1, 1'b1, 1'b0, 1'b0);
    also(2, "iadd_r1.sx", 32'h0000000A, 1'b1, 1'b1, 1'b0, 1'b0);
    op(itype(FN_ADD, 5'd2, 5'd2, 16'hFFF8), 0, "iadd_r2", 32'h0000FFF8, 1'b0);
    also(1, "iadd_r2.nf", 32'h0000FFF8, 1'b1, 1'b1, 1'b0, 1'b0);
    also(2, "iadd_r2.sx", 32'hFFFFFFF8, 1'b1, 1'b1, 1'b0, 1'b0);
    op(rtype(FN_ADD, 5'd8, 5'd1, 5'd2), 0, "fwd_add_r8", 32'h00010002, 1'b0);
    also(1, "stale_add_r8.nf", 32'h0000000A, 1'b1, 1'b1, 1'b0, 1'b0);
    also(2, "fwd_add_r8.sx", 32'h00000002, 1'b1, 1'b1, 1'b0, 1'b0);
    op(rtype(FN_ADD, 5'd9, 5'd8, 5'd8), 0, "fwd_both", 32'h00020004, 1'b0);
    also(1, "stale_both.nf", 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);
    also(2, "fwd_both.sx", 32'h00000004, 1'b1, 1'b1, 1'b0, 1'b0);

    // Same chain with one gap: forwarding not needed
    op(itype(FN_ADD, 5'd11, 5'd11, 16'h000A), 0, "gap_r11", 32'h0000000A, 1'b0);
    also(1, "gap_r11.nf", 32'h0000000A, 1'b1, 1'b1, 1'b0, 1'b0);
    op(itype(FN_ADD, 5'd12, 5'd12, 16'hFFF8), 0, "gap_r12", 32'h0000FFF8, 1'b0);
    also(1, "gap_r12.nf", 32'h0000FFF8, 1'b1, 1'b1, 1'b0, 1'b0);
    bub(0, "gap_bub", 32'h0000FFF8, 1'b1);
    also(1, "gap_bub.nf", 32'h0000FFF8, 1'b1, 1'b0, 1'b0, 1'b0);
    op(rtype(FN_ADD, 5'd13, 5'd11, 5'd12), 0, "gap_add", 32'h00010002, 1'b0);
    also(1, "gap_add.nf", 32'h00010002, 1'b1, 1'b1, 1'b0, 1'b0);

    op(itype(FN_SLT, 5'd6, 5'd6, 16'hFFF8), 0, "slt_zx", 32'h00000001, 1'b0);
    also(2, "slt_sx", 32'h00000000, 1'b1, 1'b1, 1'b0, 1'b0);

    // Build 0x80000000 by repeated doubling, then probe overflow corners
    op(itype(FN_ADD, 5'd23, 5'd0, 16'h8000), 0, "seed", 32'h00008000, 1'b0);
    dbl = 32'h00008000;
    for (int i = 0; i < 16; i++) begin
      dbl = dbl << 1;
      op(rtype(FN_ADD, 5'd23, 5'd23, 5'd23), 0, $sformatf("dbl%0d", i), dbl, (i == 15));
    end
    op(rtype(FN_NOT, 5'd24, 5'd23, 5'd0), 0, "not_min", 32'h7FFFFFFF, 1'b0);
    op(itype(FN_ADD, 5'd25, 5'd24, 16'h0001), 0, "add_ovf", 32'h80000000, 1'b1);
    op(itype(FN_ADD, 5'd22, 5'd0, 16'h0001), 0, "one", 32'h00000001, 1'b0);
    op(rtype(FN_SUB, 5'd26, 5'd0, 5'd22), 0, "sub_0m1", 32'hFFFFFFFF, 1'b0);
    op(rtype(FN_SUB, 5'd21, 5'd25, 5'd22), 0, "sub_ovf", 32'h7FFFFFFF, 1'b1);
    op(rtype(FN_AND, 5'd20, 5'd24, 5'd25), 0, "and", 32'h00000000, 1'b0);
    op(rtype(FN_XOR, 5'd19, 5'd24, 5'd25), 0, "xor", 32'hFFFFFFFF, 1'b0);
    op(itype(FN_OR, 5'd18, 5'd22, 16'h00F0), 0, "ior", 32'h000000F1, 1'b0);
    op(rtype(FN_SLT, 5'd17, 5'd25, 5'd22), 0, "slt_neg", 32'h00000001, 1'b0);

    // Illegal opcodes between dependent legal instructions
    op(itype(FN_ADD, 5'd27, 5'd0, 16'h0055), 0, "pre_ill", 32'h00000055, 1'b0);
    issue({6'b000000, 5'd27, 5'd27, 16'h0001}, 1'b1, 1'b1, 0, "ill_000000",
          32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue({6'b010000, 5'd27, 5'd27, 16'h0001}, 1'b1, 1'b1, 0, "ill_fn0",
          32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    issue({6'b110010, 5'd27, 5'd27, 16'h0001}, 1'b1, 1'b1, 0, "ill_class",
          32'h0, 1'b1, 1'b0, 1'b0, 1'b1);
    op(rtype(FN_OR, 5'd28, 5'd27, 5'd27), 0, "post_ill", 32'h00000055, 1'b0);
    bub(0, "post_ill_bub", 32'h00000055, 1'b1);

    // WriteEnable=0 executes but neither writes nor forwards
    issue(itype(FN_ADD, 5'd29, 5'd0, 16'h0077), 1'b1, 1'b0, 0, "we0",
          32'h00000077, 1'b1, 1'b1, 1'b0, 1'b0);
    op(rtype(FN_OR, 5'd30, 5'd29, 5'd29), 0, "we0_nofwd", 32'h0, 1'b0);
    bub(0, "we0_bub", 32'h0, 1'b1);
    op(rtype(FN_OR, 5'd16, 5'd29, 5'd29), 0, "we0_nowrite", 32'h0, 1'b0);

    // 16-bit datapath
    op(itype(FN_ADD, 5'd14, 5'd0, 16'h000A), 3, "w16_seed", 32'h0000000A, 1'b0);
    op(rtype(FN_NOT, 5'd15, 5'd14, 5'd0), 3, "w16_not", 32'h0000FFF5, 1'b0);
    op(itype(FN_ADD, 5'd10, 5'd0, 16'h7FFF), 3, "w16_max", 32'h00007FFF, 1'b0);
    op(itype(FN_ADD, 5'd10, 5'd10, 16'h0001), 3, "w16_ovf", 32'h00008000, 1'b1);

    // Reset while an ADD sits in EX/WB
    op(itype(FN_ADD, 5'd5, 5'd0, 16'h1234), 0, "rst_add", 32'h00001234, 1'b0);
    bub(0, "rst_bub", 32'h0, 1'b0);
    @(negedge clk);
    #2 rst_n = 1'b0;
    #1 all_zero("async_rst");
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    op(rtype(FN_OR, 5'd7, 5'd5, 5'd5), 0, "rst_nowb", 32'h0, 1'b0);
    bub(0, "tail_bub", 32'h0, 1'b1);

    repeat (4) @(negedge clk);
    checks++;
    assert (sb.size() == 0) else begin
      errors++;
      $error("FAIL drain: observed %0d pending, expected 0", sb.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/alu_pipeline_fwd.md
# alu_pipeline_fwd

Parametrised three-stage (decode/register-read, execute, write-back) ALU pipeline with an internal register file. It executes the team's 32-bit R/I instruction format and generalises the earlier fixed-width pipeline in three ways:

- configurable data width;
- selectable immediate extension;
- result forwarding, so back-to-back dependent instructions need no software-inserted gaps.

It also adds per-instruction valid, overflow and illegal-opcode signalling.

## Interface
- DATA_W, 32, datapath and register width; legal values are 16 to 64.
- SIGN_EXT_IMM, 0, 0 zero-extends imm16 to DATA_W; 1 sign-extends it.
- FORWARD_EN, 1, 1 enables the EX/WB to decode forwarding path; 0 disables it, so software must insert one gap between dependent instructions.
- Clk  input  1  the single clock; all state updates on its rising edge.
- Reset  input  1  asynchronous, active-low reset.
- InstrIn  input  32  instruction word; sampled on each edge where InstrValid=1.
- InstrValid  input  1  qualifies InstrIn; when 0 a bubble enters the pipe.
- WriteEnable  input  1  sampled with InstrIn; when 0 the instruction executes but neither writes the register file nor forwards.
- ALUOut  output  DATA_W  registered result of the instruction now in EX/WB.
- OutValid  output  1  ALUOut holds a legal, valid instruction's result.
- Ovf  output  1  signed overflow of that instruction's add/sub; 0 for all other ops.
- IllegalOp  output  1  one-cycle pulse aligned with the EX/WB slot of an illegal instruction.

## Operation
- Instruction fields:
  - [31:26] opcode; [25:21] rd; [20:16] rs.
  - R-type: [15:11] rt, with [10:0] ignored.
  - I-type: [15:0] imm16.
- Opcode decode:
  - opcode[5:4] must equal 2'b01, otherwise the instruction is illegal.
  - opcode[3]=0 selects R-type (operand B = rt); opcode[3]=1 selects I-type (operand B = ext(imm16)).
- opcode[2:0] function:
  - 001 NOT: ~A.
  - 010 ADD: A+B.
  - 011 SUB: A-B.
  - 100 OR.
  - 101 AND.
  - 110 SLT: signed A<B, giving 1 or 0 zero-extended.
  - 111 XOR.
  - 000 is illegal.
- Operand A is always rs.
- Arithmetic:
  - All arithmetic is modulo 2^DATA_W.
  - Ovf on ADD = operand signs equal and result sign differs.
  - Ovf on SUB = operand signs differ and result sign differs from A.
- Register file: 32 x DATA_W, two combinational read ports, one write port.
  - r0 is an ordinary writable register.
  - All registers clear to 0 on reset.
- Stage 1 (IR): on each edge, capture InstrIn, InstrValid and WriteEnable.
- Stage 2 (EX): decode IR, read rs and rt, apply forwarding, compute the result.
  - On the edge, load ALUOut, Ovf, the dest index and the write flag.
  - OutValid = IR valid AND legal.
  - IllegalOp = IR valid AND illegal.
- Stage 3 (WB): on the edge, write ALUOut to reg[dest] if OutValid AND the write flag are both set.
- Forwarding (FORWARD_EN=1): a source index equal to EX/WB dest, while that slot's OutValid AND write flag are set, takes ALUOut instead of the register-file value.
  - The check is independent for A and B.
  - Two-back dependencies read the already-written register file; no bypass is needed.
- Illegal instructions and bubbles:
  - Illegal: no write, ALUOut loads 0, Ovf=0.
  - Bubble: OutValid=0, ALUOut holds its previous value, no write.

## Timing
- Reset asserted: ALUOut=0, OutValid=0, Ovf=0, IllegalOp=0, IR valid=0, all registers 0.
  - Takes effect immediately, regardless of Clk.
- Reset mid-operation: in-flight instructions are discarded, and their pending write-back does not occur.
- Reset deassertion: the first instruction is sampled on the first rising edge with Reset=1.
- Latency: an instruction sampled at edge k appears on ALUOut/OutValid after edge k+1 and writes the register file at edge k+2.
- Throughput: one instruction per cycle with no stalls.
- Same-edge write: a WB write and a new EX/WB load occurring on one edge are both honoured.
- Simultaneous hazard: if rs==rt==EX/WB dest, both operands are forwarded.
- Outputs are fully registered; no combinational path from any input to any output.

## Test plan
- Reset=0 for 10 cycles, then release, then 8 bubbles -> ALUOut=0, OutValid=0 throughout; registers read back 0.
- DATA_W=32, SIGN_EXT_IMM=0, issued back-to-back:
  - I-ADD r1,r1,0x000A -> ALUOut=0000000A.
  - I-ADD r2,r2,0xFFF8 -> 0000FFF8.
  - R-ADD r8=r1+r2 -> 00010002 via the forward path.
  - Repeat with FORWARD_EN=0 and one gap inserted -> same values.
- SIGN_EXT_IMM=1: I-ADD r2,r2,0xFFF8 -> FFFFFFF8; then I-SLT r6,r6,0xFFF8 with r6=0 -> 0.
- ADD 7FFFFFFF+1 -> ALUOut=80000000, Ovf=1; SUB 0-1 -> FFFFFFFF, Ovf=0.
- Opcode 000000 -> IllegalOp pulse and OutValid=0 after 2 edges, no register change.
  - Legal instructions issued directly before and after it complete correctly.
- Reset asserted while an ADD is in EX/WB -> the target register stays 0 and the outputs clear immediately.
- DATA_W=16 regression: NOT of 0x000A -> FFF5.
